screen_image_loader: RTL
========================

# screen_image_loader

Full-screen image blitter that streams a stored bitmap from an external synchronous ROM to the VGA adapter's plot interface, one pixel per clock. It generalises the single-image game-over loader to parametrised resolution, colour depth, ROM latency and image count. It adds a start/busy/done handshake, a latched image select and optional transparent-colour skipping. It sits between the game FSM (start, image select) and the `vga_adapter` plot port.

## Interface

Parameters:
- `X_PIXELS`, 320: frame width in pixels.
- `Y_PIXELS`, 240: frame height in pixels.
- `X_W`, 9: width of `oX`; must satisfy 2^X_W ≥ X_PIXELS.
- `Y_W`, 8: width of `oY`; must satisfy 2^Y_W ≥ Y_PIXELS.
- `COLOUR_W`, 3: bits per pixel.
- `NUM_IMAGES`, 4: number of images stored back-to-back in the ROM.
- `SEL_W`, 2: width of `iImageSel`.
- `ADDR_W`, 19: ROM address width; must satisfy 2^ADDR_W ≥ NUM_IMAGES·X_PIXELS·Y_PIXELS.
- `ROM_LATENCY`, 1: cycles from `oRomAddr` to valid `iRomData`; legal range 1–4.
- `TRANSPARENT_EN`, 0: when 1, pixels equal to `TRANSPARENT_COLOUR` are not plotted.
- `TRANSPARENT_COLOUR`, 0: key colour, COLOUR_W bits.

Ports:
- `iClock` in 1: system clock; all state changes on the rising edge.
- `iResetn` in 1: asynchronous, active-low reset.
- `iStart` in 1: level-sampled request to draw a frame.
- `iImageSel` in SEL_W: image index; sampled only on an accepted start.
- `oRomAddr` out ADDR_W: registered ROM read address.
- `iRomData` in COLOUR_W: ROM read data.
- `oX` out X_W, `oY` out Y_W: pixel coordinates.
- `oColour` out COLOUR_W: pixel colour.
- `oPlot` out 1: plot enable for the current `oX`/`oY`/`oColour`.
- `oBusy` out 1: high from the accepted start until `oDone`.
- `oDone` out 1: one-cycle pulse when the frame has been fully emitted.

## Operation

- States: IDLE, FETCH, DRAIN, DONE.
- **IDLE.** When `iStart`=1 at a clock edge:
  - Latch `iImageSel` as `sel`. An index ≥ NUM_IMAGES is clamped to NUM_IMAGES-1.
  - Set x=y=0 and `oRomAddr` = sel·X_PIXELS·Y_PIXELS.
  - Set `oBusy`=1 and go to FETCH.
- **FETCH.** Each cycle, issue one address, `base + y·X_PIXELS + x`, computed incrementally with no multiplier in the per-pixel path.
  - x increments each cycle.
  - At x = X_PIXELS-1, x wraps to 0 and y increments.
  - After issuing (X_PIXELS-1, Y_PIXELS-1), go to DRAIN.
- **Coordinate pipeline.** Each issued (x, y) pair plus a valid bit travels through a ROM_LATENCY-deep delay line, so coordinates stay aligned with `iRomData`.
- **Output register.** Loads `oX`/`oY`/`oColour` from the pipeline head and `iRomData`.
  - `oPlot` = valid AND NOT (TRANSPARENT_EN AND `iRomData` == TRANSPARENT_COLOUR).
  - Coordinates still update for skipped pixels.
- **DRAIN.** Waits until the pipeline is empty, then goes to DONE.
- **DONE.** Asserts `oDone`=1 for one cycle, then `oBusy`=0, and returns to IDLE.
- `iStart` is ignored in FETCH, DRAIN and DONE. No queuing.
- `iStart` held high re-triggers a new frame on the first IDLE cycle after DONE.
- `iImageSel` changes during a frame have no effect.

## Timing

- **Reset.** On `iResetn`=0, asynchronously and immediately:
  - State goes to IDLE.
  - `oX`, `oY`, `oColour`, `oRomAddr`, `oPlot`, `oBusy`, `oDone` all go to 0.
  - The pipeline valid bits clear.
- **Reset mid-frame.** Aborts with no `oDone`; no further `oPlot` after reset is released.
- **Cycle numbering.** Edge 0 is the edge that accepts the start; N = X_PIXELS·Y_PIXELS; L = ROM_LATENCY.
- Pixel n's address is on `oRomAddr` after edge n.
- Pixel n's data is valid after edge n+L.
- Pixel n appears on the outputs after edge n+L+1.
- First `oPlot` is high after edge L+1; last after edge N+L.
- `oDone` is high only in the cycle after edge N+L+1.
- `oBusy` is high after edges 0 through N+L+1 inclusive.
- The next accepted start is at edge N+L+2 at the earliest.
- Throughput: one pixel per clock, with no bubbles inside a frame.

## Test plan

Bench parameters: X_PIXELS=4, Y_PIXELS=2, COLOUR_W=3, NUM_IMAGES=2, ROM model with ROM contents = address mod 8.

- **Basic frame.** L=1; pulse `iStart` with `iImageSel`=0.
  - `oPlot` high after edges 2–9.
  - (oX,oY) sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,1).
  - `oColour` sequence 0…7.
  - `oDone` high only after edge 10; `oBusy` falls with it.
- **Image select.** `iImageSel`=1 at start, changed to 0 mid-frame.
  - `oRomAddr` runs 8…15.
  - `oColour` sequence 0…7, taken from image 1.
- **Latency 3.** L=3, otherwise as the basic frame.
  - First `oPlot` after edge 4.
  - `oDone` after edge 12.
  - Coordinate/colour pairing identical to the basic frame.
- **Transparency.** TRANSPARENT_EN=1, TRANSPARENT_COLOUR=5.
  - Exactly 7 plots.
  - No `oPlot` while (oX,oY)=(1,1); `oX`/`oY` still step through it.
- **Start handling.** Hold `iStart` high for the whole run.
  - Back-to-back frames; second frame's first address issued after edge 11 (L=1).
  - A start pulse mid-frame is ignored: exactly one `oDone`.
- **Async reset mid-frame.** Assert `iResetn`=0 between edges 5 and 6.
  - All outputs 0 immediately.
  - No `oDone`.
  - A subsequent start produces a complete, correct frame.

Source files
------------

// File: rtl/screen_image_loader.sv
// screen_image_loader: streams one stored bitmap from a synchronous ROM to the
// VGA plot port, one pixel per clock, with a start/busy/done handshake.
module screen_image_loader #(
    parameter int X_PIXELS           = 320,
    parameter int Y_PIXELS           = 240,
    parameter int X_W                = 9,
    parameter int Y_W                = 8,
    parameter int COLOUR_W           = 3,
    parameter int NUM_IMAGES         = 4,
    parameter int SEL_W              = 2,
    parameter int ADDR_W             = 19,
    parameter int ROM_LATENCY        = 1,
    parameter int TRANSPARENT_EN     = 0,
    parameter int TRANSPARENT_COLOUR = 0
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iStart,
    input  logic [SEL_W-1:0]    iImageSel,
    output logic [ADDR_W-1:0]   oRomAddr,
    input  logic [COLOUR_W-1:0] iRomData,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);

    localparam int unsigned         LAT          = ROM_LATENCY;
    localparam int unsigned         FRAME_PIXELS = X_PIXELS * Y_PIXELS;
    localparam logic [X_W-1:0]      X_LAST       = X_W'(X_PIXELS - 1);
    localparam logic [Y_W-1:0]      Y_LAST       = Y_W'(Y_PIXELS - 1);
    localparam logic [COLOUR_W-1:0] KEY_COLOUR   = COLOUR_W'(TRANSPARENT_COLOUR);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} stateT;

    stateT state, stateNext;

    // Coordinates of the pixel whose address is currently on oRomAddr
    logic [X_W-1:0]   curX;
    logic [Y_W-1:0]   curY;

    // Coordinate delay line, head is index LAT-1 (aligned with iRomData)
    logic [X_W-1:0]   pipeX [LAT];
    logic [Y_W-1:0]   pipeY [LAT];
    logic [LAT-1:0]   pipeValid;

    logic             accept;
    logic             lastPixel;
    logic             drainEmpty;
    logic             keyHit;
    logic [SEL_W-1:0] selClamped;
    logic [ADDR_W-1:0] imageBase;

    // Clamp the image index and form the image base address (used only on start)
    always_comb begin
        selClamped = iImageSel;
        if ({1'b0, iImageSel} >= (SEL_W + 1)'(NUM_IMAGES)) begin
            selClamped = SEL_W'(NUM_IMAGES - 1);
        end
        imageBase = ADDR_W'(selClamped) * ADDR_W'(FRAME_PIXELS);
    end

    // Next-state logic; DRAIN exits once only the head stage still holds data,
    // so the last pixel leaves the output register as DONE is entered
    always_comb begin
        stateNext  = state;
        accept     = (state == IDLE) && iStart;
        lastPixel  = (curX == X_LAST) && (curY == Y_LAST);
        drainEmpty = 1'b1;
        for (int unsigned i = 1; i < LAT; i++) begin
            if (pipeValid[i-1]) begin
                drainEmpty = 1'b0;
            end
        end
        keyHit = (TRANSPARENT_EN != 0) && (iRomData == KEY_COLOUR);
        case (state)
            IDLE:    if (iStart)     stateNext = FETCH;
            FETCH:   if (lastPixel)  stateNext = DRAIN;
            DRAIN:   if (drainEmpty) stateNext = DONE;
            DONE:                    stateNext = IDLE;
            default:                 stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Address generator and handshake: incremental address, x/y raster walk
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            curX     <= '0;
            curY     <= '0;
            oRomAddr <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            oDone <= (state == DONE);
            if (state == IDLE) begin
                oBusy <= iStart;
            end
            if (accept) begin
                curX     <= '0;
                curY     <= '0;
                oRomAddr <= imageBase;
            end else if ((state == FETCH) && !lastPixel) begin
                oRomAddr <= oRomAddr + 1'b1;
                if (curX == X_LAST) begin
                    curX <= '0;
                    curY <= curY + 1'b1;
                end else begin
                    curX <= curX + 1'b1;
                end
            end
        end
    end

    // Coordinate delay line matching the ROM read latency
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            pipeValid <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                pipeX[i] <= '0;
                pipeY[i] <= '0;
            end
        end else begin
            pipeValid[0] <= (state == FETCH);
            pipeX[0]     <= curX;
            pipeY[0]     <= curY;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeX[i]     <= pipeX[i-1];
                pipeY[i]     <= pipeY[i-1];
            end
        end
    end

    // Output register: pairs the pipeline head with ROM data, masks key colour
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
        end else begin
            oPlot <= pipeValid[LAT-1] && !keyHit;
            if (pipeValid[LAT-1]) begin
                oX      <= pipeX[LAT-1];
                oY      <= pipeY[LAT-1];
                oColour <= iRomData;
            end
        end
    end

endmodule
